// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : breakout_game_ctrl
// Purpose  : Breakout game-flow sequencer: state machine, lives, score, serve timer.
// Revision : 1.0
// ============================================================================
module breakout_game_ctrl #(
    parameter int INIT_LIVES   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_W      = 8,
    parameter int BRICK_POINTS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_shoot,
    input  logic               frame_tick,
    input  logic               brick_hit,
    input  logic               ball_lost,
    input  logic               bricks_clear,
    output logic [2:0]         state,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_won,
    output logic               game_over,
    output logic               ball_enable,
    output logic               paddle_enable,
    output logic               ball_reset
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_GAME_OVER = 3'd4,
        S_WON       = 3'd5
    } state_t;

    localparam logic [1:0]       c_init_lives   = 2'(INIT_LIVES);
    localparam logic [7:0]       c_serve_frames = 8'(SERVE_FRAMES);
    localparam logic [SCORE_W:0] c_brick_points = (SCORE_W+1)'(BRICK_POINTS);

    state_t               r_state;
    logic [1:0]           r_lives;
    logic [SCORE_W-1:0]   r_score;
    logic [7:0]           r_serve_cnt;
    logic                 r_prev_start;
    logic                 r_prev_pause;
    logic                 r_prev_shoot;
    logic                 r_game_won;
    logic                 r_game_over;
    logic                 r_ball_en;
    logic                 r_paddle_en;
    logic                 r_ball_reset;

    logic                 w_start_ev;
    logic                 w_pause_ev;
    logic                 w_shoot_ev;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_sat;
    state_t               w_state_nxt;
    logic [1:0]           w_lives_nxt;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_ball_reset_nxt;

    assign w_start_ev = btn_start & ~r_prev_start;
    assign w_pause_ev = btn_pause & ~r_prev_pause;
    assign w_shoot_ev = btn_shoot & ~r_prev_shoot;

    // One spare bit catches the carry so the score clamps instead of wrapping
    assign w_score_sum = {1'b0, r_score} + c_brick_points;
    assign w_score_sat = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_lives_nxt      = r_lives;
        w_score_nxt      = r_score;
        w_cnt_nxt        = r_serve_cnt;
        w_ball_reset_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_GAME_OVER, S_WON: begin
                if (w_start_ev) begin
                    w_state_nxt      = S_SERVE;
                    w_lives_nxt      = c_init_lives;
                    w_score_nxt      = '0;
                    w_cnt_nxt        = c_serve_frames;
                    w_ball_reset_nxt = 1'b1;
                end
            end
            S_SERVE: begin
                if (w_shoot_ev) begin
                    w_state_nxt = S_PLAY;
                end else if (frame_tick) begin
                    w_cnt_nxt = r_serve_cnt - 8'd1;
                    if (r_serve_cnt <= 8'd1) begin
                        w_state_nxt = S_PLAY;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end
            S_PLAY: begin
                // Points land before the win/loss decision in the same cycle
                if (brick_hit) begin
                    w_score_nxt = w_score_sat;
                end
                if (bricks_clear) begin
                    w_state_nxt = S_WON;
                end else if (ball_lost) begin
                    if (r_lives > 2'd1) begin
                        w_lives_nxt      = r_lives - 2'd1;
                        w_state_nxt      = S_SERVE;
                        w_cnt_nxt        = c_serve_frames;
                        w_ball_reset_nxt = 1'b1;
                    end else begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = S_GAME_OVER;
                    end
                end else if (w_pause_ev) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_ev) begin
                    w_state_nxt = S_PLAY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // History bits reset high so a button held through reset is not an event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lives      <= c_init_lives;
            r_score      <= '0;
            r_serve_cnt  <= 8'd0;
            r_prev_start <= 1'b1;
            r_prev_pause <= 1'b1;
            r_prev_shoot <= 1'b1;
            r_game_won   <= 1'b0;
            r_game_over  <= 1'b0;
            r_ball_en    <= 1'b0;
            r_paddle_en  <= 1'b0;
            r_ball_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_score      <= w_score_nxt;
            r_serve_cnt  <= w_cnt_nxt;
            r_prev_start <= btn_start;
            r_prev_pause <= btn_pause;
            r_prev_shoot <= btn_shoot;
            r_game_won   <= (w_state_nxt == S_WON);
            r_game_over  <= (w_state_nxt == S_GAME_OVER);
            r_ball_en    <= (w_state_nxt == S_PLAY);
            r_paddle_en  <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_SERVE);
            r_ball_reset <= w_ball_reset_nxt;
        end
    end

    assign state         = r_state;
    assign lives         = r_lives;
    assign score         = r_score;
    assign game_won      = r_game_won;
    assign game_over     = r_game_over;
    assign ball_enable   = r_ball_en;
    assign paddle_enable = r_paddle_en;
    assign ball_reset    = r_ball_reset;

endmodule
`default_nettype wire
